// File: rtl/apb_i2c_pkg.sv
// apb_i2c_pkg: shared defaults, APB register map and FIFO event record.
package apb_i2c_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic [7:0] {
        ADDR_TX      = 8'h02,
        ADDR_RX      = 8'h04,
        ADDR_CONFIG  = 8'h08,
        ADDR_TIMEOUT = 8'h0C
    } apb_addr_e;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic err;
    } fifo_evt_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/apb_i2c_fifo_if.sv
// apb_i2c_fifo_if: strobe/data/status bundle between the APB slave and one FIFO.
interface apb_i2c_fifo_if
    import apb_i2c_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) ();
    localparam int LW = lvl_w(DEPTH);

    logic              FLUSH;
    logic              WR_EN;
    logic [DATA_W-1:0] WR_DATA;
    logic              RD_EN;
    logic [DATA_W-1:0] RD_DATA;
    logic              FULL;
    logic              EMPTY;
    logic              ALMOST_FULL;
    logic              ALMOST_EMPTY;
    logic [LW-1:0]     LEVEL;
    logic              OVERFLOW;
    logic              UNDERFLOW;
    logic              ERROR;

    modport master (
        output FLUSH, WR_EN, WR_DATA, RD_EN,
        input  RD_DATA, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, LEVEL, OVERFLOW, UNDERFLOW, ERROR
    );

    modport slave (
        input  FLUSH, WR_EN, WR_DATA, RD_EN,
        output RD_DATA, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, LEVEL, OVERFLOW, UNDERFLOW, ERROR
    );
endinterface

// File: rtl/apb_i2c_fifo_mem.sv
// apb_i2c_fifo_mem: storage array, synchronous write, asynchronous read for FWFT.
module apb_i2c_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/apb_i2c_fifo.sv
// apb_i2c_fifo: first-word-fall-through FIFO with level, watermark and error flags.
// Occupancy is a dedicated register; FULL/EMPTY decode from it, never from pointers.
module apb_i2c_fifo
    import apb_i2c_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic           PCLK,
    input  logic           PRESETn,
    apb_i2c_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]     lvl_q, lvl_d;
    fifo_evt_t         evt_q, evt_d;
    logic              full, empty, push, pop, clr;
    logic [DATA_W-1:0] head;

    always_comb begin
        full      = lvl_q == LW'(DEPTH);
        empty     = lvl_q == '0;
        push      = bus.WR_EN & (~full | bus.RD_EN);
        pop       = bus.RD_EN & ~empty;
        wptr_d    = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d    = pop ? rptr_q + PW'(1) : rptr_q;
        lvl_d     = (push & ~pop) ? lvl_q + LW'(1) : (pop & ~push) ? lvl_q - LW'(1) : lvl_q;
        evt_d.ovf = bus.WR_EN & full & ~bus.RD_EN;
        evt_d.unf = bus.RD_EN & empty;
        evt_d.err = evt_q.err | evt_d.ovf | evt_d.unf;
    end

    // Flush shares the reset path so it also suppresses same-cycle pulses.
    assign clr = ~PRESETn | bus.FLUSH;

    always_ff @(posedge PCLK)
        if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
            lvl_q  <= '0;
            evt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            lvl_q  <= lvl_d;
            evt_q  <= evt_d;
        end

    apb_i2c_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk_i   (PCLK),
        .we_i    (push & ~clr),
        .waddr_i (wptr_q),
        .wdata_i (bus.WR_DATA),
        .raddr_i (rptr_q),
        .rdata_o (head)
    );

    assign bus.RD_DATA      = empty ? '0 : head;
    assign bus.FULL         = full;
    assign bus.EMPTY        = empty;
    assign bus.ALMOST_FULL  = lvl_q >= LW'(AF_LVL);
    assign bus.ALMOST_EMPTY = lvl_q <= LW'(AE_LVL);
    assign bus.LEVEL        = lvl_q;
    assign bus.OVERFLOW     = evt_q.ovf;
    assign bus.UNDERFLOW    = evt_q.unf;
    assign bus.ERROR        = evt_q.err;
endmodule

// File: tb/tb_apb_i2c_fifo.sv
// tb_apb_i2c_fifo: directed vector table plus hand-written wrap/overflow/flush sequences.
module tb_apb_i2c_fifo;
    import apb_i2c_pkg::*;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_i2c_fifo_if bus ();
    apb_i2c_fifo dut (.PCLK(PCLK), .PRESETn(PRESETn), .bus(bus));

    // flag order: {FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW, ERROR}
    typedef struct {
        logic        rstn, flush, wr, rd;
        logic [31:0] wd;
        logic [4:0]  lvl;
        logic [31:0] rdata;
        logic [6:0]  flg;
    } vec_t;

    int tests = 0;
    int fails = 0;
    vec_t v [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rstn, input logic flush, input logic wr, input logic rd, input logic [31:0] wd);
        PRESETn     = rstn;
        bus.FLUSH   = flush;
        bus.WR_EN   = wr;
        bus.RD_EN   = rd;
        bus.WR_DATA = wd;
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] lvl, input logic [31:0] rd, input logic [6:0] flg);
        chk({tag, "_level"}, 32'(bus.LEVEL), 32'(lvl));
        chk({tag, "_rdata"}, bus.RD_DATA, rd);
        chk({tag, "_flags"}, 32'({bus.FULL, bus.EMPTY, bus.ALMOST_FULL, bus.ALMOST_EMPTY,
                                  bus.OVERFLOW, bus.UNDERFLOW, bus.ERROR}), 32'(flg));
    endtask

    function automatic logic [31:0] strm(input int j);
        return j < 16 ? 32'h200 + 32'(j) : 32'h9900 + 32'(j - 16);
    endfunction

    initial begin
        PRESETn = 1'b0; bus.FLUSH = 1'b0; bus.WR_EN = 1'b0; bus.RD_EN = 1'b0; bus.WR_DATA = '0;
        //         rstn  fl    wr    rd    wdata         lvl  rdata         flags
        v[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 32'h0,        7'b0101000};
        v[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 32'h0,        7'b0101000};
        v[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 32'h0,        7'b0101000};
        v[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hA5A50001, 5'd1, 32'hA5A50001, 7'b0001000};
        v[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd1, 32'hA5A50001, 7'b0001000};
        v[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        5'd0, 32'h0,        7'b0101000};
        v[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h55,       5'd1, 32'h55,       7'b0001011};
        v[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd1, 32'h55,       7'b0001001};
        v[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h11,       5'd2, 32'h55,       7'b0001001};
        v[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h22,       5'd3, 32'h55,       7'b0000001};
        v[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h33,       5'd0, 32'h0,        7'b0101000};
        v[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        5'd0, 32'h0,        7'b0101011};
        v[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 32'h0,        7'b0101001};
        v[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h44,       5'd0, 32'h0,        7'b0101000};
        v[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 32'h0,        7'b0101000};
        for (int i = 0; i < 15; i++) begin
            drive(v[i].rstn, v[i].flush, v[i].wr, v[i].rd, v[i].wd);
            check($sformatf("vec%0d", i), v[i].lvl, v[i].rdata, v[i].flg);
        end

        // fill to full, watch watermarks, then overflow
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'(i));
            check($sformatf("fill%0d", i), 5'(i + 1), 32'h0,
                  {i == 15, 1'b0, (i + 1) >= 14, (i + 1) <= 2, 3'b000});
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD);
        check("ovf", 5'd16, 32'h0, 7'b1010101);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("ovf_after", 5'd16, 32'h0, 7'b1010001);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_head", i), bus.RD_DATA, 32'(i));
            drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
            chk($sformatf("drain%0d_level", i), 32'(bus.LEVEL), 32'(15 - i));
        end
        check("drained", 5'd0, 32'h0, 7'b0101001);
        drive(1'b1, 1'b1, 1'b0, 0, 32'h0);
        check("flush_err", 5'd0, 32'h0, 7'b0101000);

        // full with simultaneous push/pop: pointers wrap, order preserved
        for (int j = 0; j < 16; j++) drive(1'b1, 1'b0, 1'b1, 1'b0, strm(j));
        check("full2", 5'd16, strm(0), 7'b1010000);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("pp%0d_head", k), bus.RD_DATA, strm(k));
            drive(1'b1, 1'b0, 1'b1, 1'b1, strm(16 + k));
            chk($sformatf("pp%0d_level", k), 32'(bus.LEVEL), 32'd16);
            chk($sformatf("pp%0d_ovf", k), 32'(bus.OVERFLOW), 32'd0);
        end
        for (int j = 20; j < 36; j++) begin
            chk($sformatf("wdrain%0d_head", j), bus.RD_DATA, strm(j));
            drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        end
        check("wdrained", 5'd0, 32'h0, 7'b0101000);

        // flush with data held and ERROR set, concurrent with a push
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h300 + 32'(i));
        check("pre_flush", 5'd5, 32'h300, 7'b0000001);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'hBAD);
        check("flush", 5'd0, 32'h0, 7'b0101000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("flush_after", 5'd0, 32'h0, 7'b0101000);

        // reset in the middle of a burst
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h400 + 32'(i));
        check("pre_rst", 5'd5, 32'h400, 7'b0000001);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hBAD);
        check("rst_mid", 5'd0, 32'h0, 7'b0101000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rst_after", 5'd0, 32'h0, 7'b0101000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
